// File: rtl/sim_cycle_timer_pkg.sv
// Shared types for the simulation run-control timer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents:
//   timer_state_e  - run-control FSM state encoding
//   TIMER_STATE_W  - width of the encoded state
package sim_timer_pkg;

    localparam int TIMER_STATE_W = 2;

    // IDLE  : waiting for start, counters frozen at their last value
    // RUN   : counting one cycle per clock
    // PAUSE : counters held while pause is high
    // DONE  : single-cycle terminal state of a bounded run
    typedef enum logic [TIMER_STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_e;

endpackage : sim_timer_pkg

// File: rtl/sim_cycle_timer_tick_channel.sv
// One periodic tick channel: phase counter that wraps at period-1.
// Latency: tick is decoded combinationally from the phase register (no input-to-output path).
// Backpressure: none; phase advances whenever count_en is high.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - synchronous phase clear (run launch)
//   count_en    - advance phase this cycle
//   period      - latched period; 0 disables the channel
//   tick        - high while phase == period-1 (caller gates with RUN)
module tick_channel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             count_en,
    input  logic [WIDTH-1:0] period,
    output logic             tick
);

    logic [WIDTH-1:0] r_phase;
    logic             w_enabled;
    logic             w_at_end;

    assign w_enabled = (period != '0);
    assign w_at_end  = w_enabled && (r_phase == (period - WIDTH'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
        end else if (clear) begin
            r_phase <= '0;
        end else if (count_en) begin
            // A disabled channel parks at 0 so enabling it on the next
            // launch always starts from a clean phase.
            if (w_at_end || !w_enabled) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + WIDTH'(1);
            end
        end
    end

    assign tick = w_at_end;

endmodule : tick_channel

// File: rtl/sim_cycle_timer.sv
// Run-control cycle timer: bounded or free-running count with pause/abort, done pulse and periodic ticks.
// Latency: start at edge k gives busy=1, cycle=0 in cycle k+1; all outputs decoded from registers.
// Backpressure: pause holds all counters; abort returns to IDLE with no done pulse.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   start        - launch a run (honoured in IDLE/DONE only)
//   pause        - level; hold counting while high
//   abort        - end the run immediately; overrides start and pause
//   run_len      - cycles per run, latched at launch; 0 = free-running
//   tick_period  - NUM_CH packed periods, latched at launch; 0 = channel off
//   cycle        - current run cycle index
//   busy         - RUN or PAUSE
//   done         - one-cycle pulse after the final counted cycle
//   tick         - per-channel periodic pulse
//   wrapped      - one-cycle pulse when a free-running count returns to 0
module sim_cycle_timer
    import sim_timer_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    abort,
    input  logic [WIDTH-1:0]        run_len,
    input  logic [NUM_CH*WIDTH-1:0] tick_period,
    output logic [WIDTH-1:0]        cycle,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_CH-1:0]       tick,
    output logic                    wrapped
);

    timer_state_e              r_state;
    timer_state_e              w_state_nxt;
    logic [WIDTH-1:0]          r_cycle;
    logic [WIDTH-1:0]          r_run_len;
    logic [NUM_CH*WIDTH-1:0]   r_tick_period;
    logic                      r_counted;     // at least one cycle counted this run
    logic                      w_launch;
    logic                      w_count_en;
    logic                      w_final;
    logic                      w_in_run;
    logic [NUM_CH-1:0]         w_tick_raw;

    assign w_in_run = (r_state == RUN);

    // Last cycle of a bounded run. The counter does not step past it, so a
    // pause taken here resumes on the same index and done follows one
    // cycle after resuming.
    assign w_final = (r_run_len != '0) && (r_cycle == (r_run_len - WIDTH'(1)));

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_count_en  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = RUN;
                    w_launch    = 1'b1;
                end
            end
            RUN: begin
                // Every RUN cycle counts, including the one in which pause
                // or abort is sampled; only the final cycle holds.
                w_count_en = !w_final;
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (pause) begin
                    w_state_nxt = PAUSE;
                end else if (w_final) begin
                    w_state_nxt = DONE;
                end
            end
            PAUSE: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (!pause) begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                // Back-to-back runs relaunch straight from DONE.
                if (start && !abort) begin
                    w_state_nxt = RUN;
                    w_launch    = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter, config latches and run-progress flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle <= '0;
        end else if (w_launch) begin
            r_cycle <= '0;
        end else if (w_count_en) begin
            r_cycle <= r_cycle + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_len     <= '0;
            r_tick_period <= '0;
        end else if (w_launch) begin
            r_run_len     <= run_len;
            r_tick_period <= tick_period;
        end
    end

    // Distinguishes cycle==0 at the start of a run from cycle==0 after a
    // free-running wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_counted <= 1'b0;
        end else if (w_launch) begin
            r_counted <= 1'b0;
        end else if (w_count_en) begin
            r_counted <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Tick channels
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_channel #(
            .WIDTH(WIDTH)
        ) u_tick_channel (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (w_launch),
            .count_en (w_count_en),
            .period   (r_tick_period[g*WIDTH +: WIDTH]),
            .tick     (w_tick_raw[g])
        );
    end

    // ------------------------------------------------------------------
    // Outputs (registers only)
    // ------------------------------------------------------------------
    assign cycle   = r_cycle;
    assign busy    = (r_state == RUN) || (r_state == PAUSE);
    assign done    = (r_state == DONE);
    assign tick    = w_tick_raw & {NUM_CH{w_in_run}};
    assign wrapped = w_in_run && (r_run_len == '0) && (r_cycle == '0) && r_counted;

endmodule : sim_cycle_timer

// File: tb/tb_sim_cycle_timer.sv
module tb_sim_cycle_timer;

    localparam int WIDTH  = 8;
    localparam int NUM_CH = 2;
    localparam int MODV   = 256;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic                    clk;
    logic                    rst_n;
    logic                    start;
    logic                    pause;
    logic                    abort;
    logic [WIDTH-1:0]        run_len;
    logic [NUM_CH*WIDTH-1:0] tick_period;
    logic [WIDTH-1:0]        cycle;
    logic                    busy;
    logic                    done;
    logic [NUM_CH-1:0]       tick;
    logic                    wrapped;

    int n_checks;
    int n_errors;

    // Reference model: run mode plus number of cycles counted since launch.
    // cycle, phases and wrap events are all derived from that count.
    int m_mode;
    int m_n;
    int m_len;
    int m_per [NUM_CH];

    int obs_busy;
    int obs_done;
    int obs_tick0;
    int obs_tick1;
    int obs_wrap;

    sim_cycle_timer #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pause       (pause),
        .abort       (abort),
        .run_len     (run_len),
        .tick_period (tick_period),
        .cycle       (cycle),
        .busy        (busy),
        .done        (done),
        .tick        (tick),
        .wrapped     (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_n    = 0;
        m_len  = 0;
        for (int i = 0; i < NUM_CH; i++) m_per[i] = 0;
    endtask

    task automatic model_launch(input logic [WIDTH-1:0] len, input logic [NUM_CH*WIDTH-1:0] per);
        m_mode = M_RUN;
        m_n    = 0;
        m_len  = int'(len);
        for (int i = 0; i < NUM_CH; i++) m_per[i] = int'(per[i*WIDTH +: WIDTH]);
    endtask

    task automatic model_step(input bit s, input bit p, input bit a,
                              input logic [WIDTH-1:0] len, input logic [NUM_CH*WIDTH-1:0] per);
        bit fin;
        case (m_mode)
            M_IDLE: if (s && !a) model_launch(len, per);
            M_RUN: begin
                fin = (m_len != 0) && (m_n == m_len - 1);
                if (!fin) m_n++;
                if (a)        m_mode = M_IDLE;
                else if (p)   m_mode = M_PAUSE;
                else if (fin) m_mode = M_DONE;
            end
            M_PAUSE: begin
                if (a)       m_mode = M_IDLE;
                else if (!p) m_mode = M_RUN;
            end
            default: begin
                if (s && !a) model_launch(len, per);
                else         m_mode = M_IDLE;
            end
        endcase
    endtask

    task automatic check_all();
        logic [NUM_CH-1:0] et;
        bit running;
        running = (m_mode == M_RUN);
        for (int i = 0; i < NUM_CH; i++)
            et[i] = running && (m_per[i] != 0) && ((m_n % m_per[i]) == m_per[i] - 1);
        chk("cycle",   32'(cycle),   32'(m_n % MODV));
        chk("busy",    32'(busy),    32'(m_mode == M_RUN || m_mode == M_PAUSE));
        chk("done",    32'(done),    32'(m_mode == M_DONE));
        chk("tick",    32'(tick),    32'(et));
        chk("wrapped", 32'(wrapped), 32'(running && m_len == 0 && m_n > 0 && (m_n % MODV) == 0));
        obs_busy  += int'(busy);
        obs_done  += int'(done);
        obs_tick0 += int'(tick[0]);
        obs_tick1 += int'(tick[1]);
        obs_wrap  += int'(wrapped);
    endtask

    task automatic clr_obs();
        obs_busy  = 0;
        obs_done  = 0;
        obs_tick0 = 0;
        obs_tick1 = 0;
        obs_wrap  = 0;
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass,
    // advance the model, then compare at the next falling edge.
    task automatic step(input bit s, input bit p, input bit a,
                        input logic [WIDTH-1:0] len, input logic [NUM_CH*WIDTH-1:0] per);
        start       = s;
        pause       = p;
        abort       = a;
        run_len     = len;
        tick_period = per;
        @(posedge clk);
        model_step(s, p, a, len, per);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        pause       = 1'b0;
        abort       = 1'b0;
        run_len     = '0;
        tick_period = '0;
        model_reset();
        clr_obs();

        // Reset state
        #12;
        chk("rst_cycle",   32'(cycle),   32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        chk("rst_tick",    32'(tick),    32'd0);
        chk("rst_wrapped", 32'(wrapped), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all();

        // Bounded run of 15, periods {3,0}
        clr_obs();
        step(1'b1, 1'b0, 1'b0, 8'd15, {8'd0, 8'd3});
        idle_steps(20);
        chk("b15_busy_cycles", 32'(obs_busy),  32'd15);
        chk("b15_done_pulses", 32'(obs_done),  32'd1);
        chk("b15_tick0",       32'(obs_tick0), 32'd5);
        chk("b15_tick1",       32'(obs_tick1), 32'd0);
        chk("b15_cycle_hold",  32'(cycle),     32'd14);

        // Run of 10 with a 4-cycle pause issued once cycle 4 is reached
        clr_obs();
        step(1'b1, 1'b0, 1'b0, 8'd10, {8'd0, 8'd3});
        idle_steps(4);
        chk("p10_cycle_before", 32'(cycle), 32'd4);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'd0, 16'd0);
            chk("p10_cycle_held", 32'(cycle), 32'd5);
        end
        idle_steps(12);
        chk("p10_busy_cycles", 32'(obs_busy),  32'd14);
        chk("p10_done_pulses", 32'(obs_done),  32'd1);
        chk("p10_tick0",       32'(obs_tick0), 32'd3);

        // Free-running with period {1,0}; abort ends it with no done
        clr_obs();
        step(1'b1, 1'b0, 1'b0, 8'd0, {8'd0, 8'd1});
        for (int i = 0; i < 599; i++) step(1'b0, 1'b0, 1'b0, 8'd9, 16'hFFFF);
        chk("fr_wraps", 32'(obs_wrap),  32'd2);
        chk("fr_tick0", 32'(obs_tick0), 32'd600);
        step(1'b0, 1'b0, 1'b1, 8'd0, 16'd0);
        idle_steps(5);
        chk("fr_abort_busy", 32'(busy),     32'd0);
        chk("fr_no_done",    32'(obs_done), 32'd0);

        // abort together with start in IDLE
        step(1'b1, 1'b0, 1'b1, 8'd5, {8'd1, 8'd1});
        chk("as_idle_busy", 32'(busy), 32'd0);
        idle_steps(2);

        // abort once cycle 7 of a 20-cycle run is reached
        clr_obs();
        step(1'b1, 1'b0, 1'b0, 8'd20, {8'd2, 8'd5});
        idle_steps(7);
        chk("ab_cycle_before", 32'(cycle), 32'd7);
        step(1'b0, 1'b0, 1'b1, 8'd0, 16'd0);
        chk("ab_busy",  32'(busy),  32'd0);
        chk("ab_cycle", 32'(cycle), 32'd8);
        idle_steps(4);
        chk("ab_no_done",   32'(obs_done), 32'd0);
        chk("ab_cycle_end", 32'(cycle),    32'd8);

        // start held high with run_len 3: back-to-back runs
        clr_obs();
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, 8'd3, {8'd2, 8'd1});
        chk("b2b_done_pulses", 32'(obs_done), 32'd3);
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_cycle",   32'(cycle),   32'd0);
        chk("mrst_busy",    32'(busy),    32'd0);
        chk("mrst_done",    32'(done),    32'd0);
        chk("mrst_tick",    32'(tick),    32'd0);
        chk("mrst_wrapped", 32'(wrapped), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all();

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            bit s, p, a;
            logic [WIDTH-1:0] len;
            logic [NUM_CH*WIDTH-1:0] per;
            s = ($urandom_range(0, 99) < 30);
            p = ($urandom_range(0, 99) < 15);
            a = ($urandom_range(0, 99) < 5);
            len = WIDTH'($urandom_range(0, 12));
            per[WIDTH-1:0]       = WIDTH'($urandom_range(0, 5));
            per[2*WIDTH-1:WIDTH] = WIDTH'($urandom_range(0, 5));
            step(s, p, a, len, per);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sim_cycle_timer

// File: doc/sim_cycle_timer.md
# sim_cycle_timer

Parametrised run-control timer for simulation benches and on-chip test harnesses. It counts clock cycles over a programmable run length, supports pause/abort, and emits a done pulse plus per-channel periodic tick pulses. Benches use it in place of hand-coded cycle counters and fixed-delay finish statements: `done` drives `$finish`, and `tick[]` drives stimulus strobes. All outputs are decoded from registers only, with no combinational input-to-output paths.

## Interface
- `WIDTH`, 8, width of cycle counter, `run_len` and each tick period.
- `NUM_CH`, 2, number of periodic tick channels (≥1).

- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled in IDLE/DONE only.
- `pause`  in  1  level; hold all counting while high.
- `abort`  in  1  terminate run immediately, no `done`.
- `run_len`  in  WIDTH  cycles per run, latched on accepted `start`; 0 = free-running.
- `tick_period`  in  NUM_CH*WIDTH  channel i period in bits [i*WIDTH +: WIDTH], latched on `start`; 0 = channel disabled.
- `cycle`  out  WIDTH  current run cycle index.
- `busy`  out  1  high in RUN or PAUSE.
- `done`  out  1  one-cycle pulse after the final counted cycle.
- `tick`  out  NUM_CH  one-cycle pulse per channel per period.
- `wrapped`  out  1  one-cycle pulse when a free-running count wraps to 0.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - `start`=1 and `abort`=0 goes to RUN.
  - Latch `run_len` and `tick_period`, clear `cycle` and all phases to 0.
- RUN:
  - Each cycle in RUN counts, so `cycle` and phases advance at the next edge unless a transition is taken.
  - `abort` goes to IDLE.
  - Otherwise, `pause` goes to PAUSE.
  - Otherwise, if `run_len`≠0 and `cycle`==`run_len`−1, go to DONE; `cycle` holds.
  - Otherwise, `cycle`+1 with WIDTH-bit wrap.
- PAUSE:
  - Counters hold.
  - `abort` goes to IDLE.
  - `pause`=0 goes to RUN.
- DONE:
  - Lasts one cycle.
  - `start` (without `abort`) goes to RUN with a fresh latch; otherwise go to IDLE.
- Tick channel i, with latched period P:
  - Phase counts 0..P−1 on each RUN cycle, then returns to 0.
  - `tick[i]` = (state==RUN) and (phase==P−1) and P≠0.
  - P=1 ticks every RUN cycle; P>`run_len` never ticks in a bounded run.
- `wrapped`: state==RUN, `run_len`==0, and `cycle`==0 on a counted cycle other than the first of the run (flag register).
- `start` in RUN/PAUSE is ignored; `run_len`/`tick_period` changes mid-run are ignored.
- `abort` takes priority over `start` and `pause`.

## Timing
- Reset values: state IDLE, `cycle`=0, `busy`=0, `done`=0, `tick`=0, `wrapped`=0, phases 0, latched config 0.
- Reset asserted mid-run forces the reset values immediately, asynchronously.
- `start` sampled at edge k gives `busy`=1 and `cycle`=0 in cycle k+1.
- Bounded run of N with no pause:
  - `busy` high for exactly N cycles, with `cycle` = 0..N−1.
  - `done` high in the cycle after `cycle`=N−1; `busy`=0 in that cycle.
  - `cycle` stays at N−1 through DONE/IDLE until the next start.
- `pause` is registered into state: `pause` sampled high at edge k holds counters from cycle k+1.
- Each PAUSE cycle delays `done` by one.
- Pausing at `cycle`=N−1 defers `done` until one cycle after resuming.
- `abort` sampled at edge k gives IDLE in cycle k+1. `done` never pulses for an aborted run; `tick` and `wrapped` are 0 from k+1.
- Back-to-back runs: `start` during DONE gives `cycle`=0 in the next cycle, with no IDLE gap.

## Structure
- Package `sim_timer_pkg`: state enum `timer_state_e` {IDLE, RUN, PAUSE, DONE}.
- Sub-module `tick_channel` (parameter WIDTH):
  - Ports: `clk`, `rst_n`, `clear`, `count_en`, `period`, `tick`.
  - Generated NUM_CH times.
- Top contains the FSM, cycle counter, config latches and `wrapped` flag.

## Test plan
- WIDTH=8, `run_len`=15, periods {3,0}, `start` pulse:
  - `cycle` goes 0..14 over 15 `busy` cycles, then `done` pulses once.
  - `tick[0]` fires at `cycle`=2,5,8,11,14.
  - `tick[1]` is never high.
- `run_len`=10, `pause` high for 4 cycles starting when `cycle`=4:
  - `cycle` holds at 5 for 4 cycles.
  - `done` arrives 4 cycles later than in an unpaused run; tick count is unchanged.
- `run_len`=0, period {1,256→0}, WIDTH=8:
  - `cycle` wraps 255→0 with a `wrapped` pulse every 256 counted cycles.
  - `tick[0]` is high every RUN cycle.
  - `abort` ends the run with no `done`.
- `abort` and `start` together in IDLE: state stays IDLE, `busy`=0.
- `abort` at `cycle`=7 of a 20-cycle run: `busy` drops next cycle, no `done`, `cycle` holds 8.
- `start` held high continuously with `run_len`=3: runs repeat with `cycle` 0,1,2,[DONE],0,1,2…; `rst_n` low mid-run clears all outputs at once.
